// File: rtl/tb_memory_regbus_mp.sv
// Multi-port regbus memory model: NumPorts target ports share one word array,
// arbitrated round-robin, each answering a fixed Latency cycles after its grant.
//
// Per-port packing (MSB..LSB):
//   request  slice p: {addr[AddrWidth], write, wdata[DataWidth], wstrb[DataWidth/8], valid}
//   response slice p: {rdata[DataWidth], error, ready}
module tb_memory_regbus_mp #(
    parameter int unsigned          NumPorts  = 2,
    parameter int unsigned          AddrWidth = 48,
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          NumWords  = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter int unsigned          Latency   = 2,
    localparam int unsigned         StrbWidth = DataWidth / 8,
    localparam int unsigned         ReqWidth  = AddrWidth + DataWidth + StrbWidth + 2,
    localparam int unsigned         RspWidth  = DataWidth + 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumPorts*ReqWidth-1:0] req_i,
    output logic [NumPorts*RspWidth-1:0] rsp_o
);

    localparam int unsigned OffBits = $clog2(StrbWidth);
    localparam int unsigned IdxW    = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned CntW    = (Latency > 1) ? $clog2(Latency) : 1;
    localparam int unsigned PtrW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    if (Latency < 1) begin : gen_chk_latency
        $error("tb_memory_regbus_mp: Latency must be at least 1");
    end
    if ((DataWidth < 8) || ((DataWidth & (DataWidth - 1)) != 0)) begin : gen_chk_width
        $error("tb_memory_regbus_mp: DataWidth must be a power of two >= 8");
    end
    if ((NumPorts < 1) || (NumPorts > 8)) begin : gen_chk_ports
        $error("tb_memory_regbus_mp: NumPorts must be in 1..8");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Unpacked request fields and per-port address decode
    logic [AddrWidth-1:0] p_addr  [NumPorts];
    logic                 p_write [NumPorts];
    logic [DataWidth-1:0] p_wdata [NumPorts];
    logic [StrbWidth-1:0] p_wstrb [NumPorts];
    logic [IdxW-1:0]      p_idx   [NumPorts];
    logic [NumPorts-1:0]  p_valid;
    logic [NumPorts-1:0]  p_oor;

    state_e               state_reg [NumPorts];
    state_e               state_next[NumPorts];
    logic [CntW-1:0]      cnt_reg   [NumPorts];
    logic [CntW-1:0]      cnt_next  [NumPorts];
    logic [DataWidth-1:0] rdata_reg [NumPorts];
    logic [DataWidth-1:0] rdata_next[NumPorts];
    logic                 err_reg   [NumPorts];
    logic                 err_next  [NumPorts];

    logic [PtrW-1:0]      ptr_reg;
    logic [PtrW-1:0]      ptr_next;
    logic                 grant_valid;
    logic [PtrW-1:0]      grant_idx;
    logic [NumPorts-1:0]  gnt;

    logic                 g_write;
    logic                 g_oor;
    logic [IdxW-1:0]      g_idx;
    logic [DataWidth-1:0] g_wdata;
    logic [StrbWidth-1:0] g_wstrb;
    logic [DataWidth-1:0] g_rdata;

    logic [DataWidth-1:0] mem_reg [NumWords];

    for (genvar gi = 0; gi < NumPorts; gi++) begin : gen_port
        logic [ReqWidth-1:0]  req_slice;
        logic [AddrWidth:0]   byte_off;
        logic [AddrWidth:0]   word_off;

        assign req_slice    = req_i[gi*ReqWidth +: ReqWidth];
        assign p_valid[gi]  = req_slice[0];
        assign p_wstrb[gi]  = req_slice[StrbWidth:1];
        assign p_wdata[gi]  = req_slice[StrbWidth+DataWidth:StrbWidth+1];
        assign p_write[gi]  = req_slice[StrbWidth+DataWidth+1];
        assign p_addr[gi]   = req_slice[ReqWidth-1 -: AddrWidth];

        // One extra bit keeps addr < BaseAddr from wrapping into a valid index
        assign byte_off     = {1'b0, p_addr[gi]} - {1'b0, BaseAddr};
        assign word_off     = byte_off >> OffBits;
        assign p_oor[gi]    = (p_addr[gi] < BaseAddr) ||
                              (word_off >= (AddrWidth+1)'(NumWords));
        assign p_idx[gi]    = word_off[IdxW-1:0];

        assign rsp_o[gi*RspWidth +: RspWidth] = (state_reg[gi] == ST_RESP) ?
            {rdata_reg[gi], err_reg[gi], 1'b1} : '0;

        a_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (state_reg[gi] == ST_WAIT) |-> p_valid[gi]);
    end

    // Round-robin: first idle requester at or after the pointer, wrapping
    always_comb begin
        logic [PtrW:0]   cand;
        logic [PtrW-1:0] cand_idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        cand_idx    = '0;
        for (int k = 0; k < NumPorts; k++) begin
            cand = {1'b0, ptr_reg} + (PtrW+1)'(k);
            if (cand >= (PtrW+1)'(NumPorts)) begin
                cand = cand - (PtrW+1)'(NumPorts);
            end
            cand_idx = cand[PtrW-1:0];
            if (!grant_valid && p_valid[cand_idx] && (state_reg[cand_idx] == ST_IDLE)) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign gnt      = grant_valid ? (NumPorts'(1) << grant_idx) : '0;
    assign ptr_next = !grant_valid ? ptr_reg :
                      (grant_idx == PtrW'(NumPorts - 1)) ? '0 : grant_idx + PtrW'(1);

    assign g_write  = p_write[grant_idx];
    assign g_oor    = p_oor[grant_idx];
    assign g_idx    = p_idx[grant_idx];
    assign g_wdata  = p_wdata[grant_idx];
    assign g_wstrb  = p_wstrb[grant_idx];
    assign g_rdata  = mem_reg[g_idx];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int w = 0; w < NumWords; w++) begin
                mem_reg[w] <= '0;
            end
        end else if (grant_valid && g_write && !g_oor) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (g_wstrb[b]) begin
                    mem_reg[g_idx][b*8 +: 8] <= g_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            state_next[p] = state_reg[p];
            cnt_next[p]   = cnt_reg[p];
            rdata_next[p] = rdata_reg[p];
            err_next[p]   = err_reg[p];
            case (state_reg[p])
                ST_IDLE: begin
                    if (gnt[p]) begin
                        err_next[p]   = g_oor;
                        rdata_next[p] = (g_write || g_oor) ? '0 : g_rdata;
                        cnt_next[p]   = CntW'(Latency - 1);
                        state_next[p] = (Latency == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Counter holds the cycles still to go before RESP
                    cnt_next[p] = cnt_reg[p] - CntW'(1);
                    if (cnt_reg[p] <= CntW'(1)) begin
                        state_next[p] = ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_next[p] = ST_IDLE;
                end
                default: begin
                    state_next[p] = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_reg <= '0;
            for (int p = 0; p < NumPorts; p++) begin
                state_reg[p] <= ST_IDLE;
                cnt_reg[p]   <= '0;
                rdata_reg[p] <= '0;
                err_reg[p]   <= 1'b0;
            end
        end else begin
            ptr_reg <= ptr_next;
            for (int p = 0; p < NumPorts; p++) begin
                state_reg[p] <= state_next[p];
                cnt_reg[p]   <= cnt_next[p];
                rdata_reg[p] <= rdata_next[p];
                err_reg[p]   <= err_next[p];
            end
        end
    end

endmodule

// File: tb/tb_tb_memory_regbus_mp.sv
// Bench for tb_memory_regbus_mp: directed transactions with literal expectations,
// plus a transaction-level reference model compared against every port each cycle.
module tb_tb_memory_regbus_mp;

    localparam int N    = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int NW   = 64;
    localparam int L    = 3;
    localparam int REQW = AW + DW + SW + 2;
    localparam int RSPW = DW + 2;
    localparam logic [AW-1:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N*REQW-1:0] req_i;
    logic [N*RSPW-1:0] rsp_o;

    logic [AW-1:0] d_addr  [N];
    logic          d_write [N];
    logic [DW-1:0] d_wdata [N];
    logic [SW-1:0] d_wstrb [N];
    logic          d_valid [N];

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    bit model_on = 0;
    bit stop = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_i = '0;
        for (int p = 0; p < N; p++) begin
            req_i[p*REQW +: REQW] = {d_addr[p], d_write[p], d_wdata[p], d_wstrb[p], d_valid[p]};
        end
    end

    tb_memory_regbus_mp #(
        .NumPorts (N),
        .AddrWidth(AW),
        .DataWidth(DW),
        .NumWords (NW),
        .BaseAddr (BASE),
        .Latency  (L)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .req_i (req_i),
        .rsp_o (rsp_o)
    );

    // Reference model: grant-order memory plus a due cycle per outstanding response
    bit            pend_m  [N];
    int unsigned   due_m   [N];
    logic [DW-1:0] rdata_m [N];
    logic          err_m   [N];
    logic [DW-1:0] mem_m   [int];
    int            ptr_m;

    initial begin : model
        int gp;
        int p;
        int widx;
        longint off;
        logic [DW-1:0] cur;
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            pend_m[i] = 0; due_m[i] = 0; rdata_m[i] = '0; err_m[i] = 0;
        end
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mem_m.delete();
                ptr_m = 0;
                for (int i = 0; i < N; i++) pend_m[i] = 0;
                model_on = 1;
            end else begin
                gp = -1;
                for (int k = 0; k < N; k++) begin
                    p = (ptr_m + k) % N;
                    if (gp < 0 && d_valid[p] && !(pend_m[p] && cyc <= due_m[p])) gp = p;
                end
                if (gp >= 0) begin
                    off = longint'(d_addr[gp]) - longint'(BASE);
                    if (off < 0 || off / 4 >= NW) begin
                        err_m[gp] = 1; rdata_m[gp] = '0;
                    end else begin
                        widx = int'(off / 4);
                        cur = mem_m.exists(widx) ? mem_m[widx] : '0;
                        err_m[gp] = 0;
                        if (d_write[gp]) begin
                            for (int b = 0; b < SW; b++)
                                if (d_wstrb[gp][b]) cur[b*8 +: 8] = d_wdata[gp][b*8 +: 8];
                            mem_m[widx] = cur;
                            rdata_m[gp] = '0;
                        end else begin
                            rdata_m[gp] = cur;
                        end
                    end
                    pend_m[gp] = 1;
                    due_m[gp] = cyc + L;
                    ptr_m = (gp + 1) % N;
                end
            end
            cyc++;
        end
    end

    initial begin : compare
        logic [RSPW-1:0] exp_r;
        logic [RSPW-1:0] got_r;
        forever begin
            @(negedge clk);
            if (model_on) begin
                for (int p = 0; p < N; p++) begin
                    exp_r = (pend_m[p] && due_m[p] == cyc) ? {rdata_m[p], err_m[p], 1'b1} : '0;
                    got_r = rsp_o[p*RSPW +: RSPW];
                    checks++;
                    if (got_r !== exp_r) begin
                        errors++;
                        $display("FAIL rsp_port%0d cyc %0d got %h exp %h", p, cyc, got_r, exp_r);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic xfer(input int p, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [SW-1:0] ws,
                        output logic [DW-1:0] rd, output logic er, output int lat);
        int start;
        bit done;
        @(negedge clk);
        d_addr[p] = a; d_write[p] = wr; d_wdata[p] = wd; d_wstrb[p] = ws; d_valid[p] = 1'b1;
        start = int'(cyc);
        done = 0; rd = '0; er = 1'b0; lat = -1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (rsp_o[p*RSPW]) begin
                rd = rsp_o[p*RSPW+2 +: DW];
                er = rsp_o[p*RSPW+1];
                lat = int'(cyc) - start;
                done = 1;
            end
        end
        d_valid[p] = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout_port%0d addr %h no ready within 64 cycles", p, a);
        end
        $display("txn port%0d %s addr %h wdata %h strb %h -> rdata %h err %0d lat %0d",
                 p, wr ? "WR" : "RD", a, wd, ws, rd, er, lat);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [DW-1:0] rd, rd0, rd1, rd2;
        logic er, er0, er1, er2;
        int lat, lat0, lat1, lat2;
        int nready;
        for (int p = 0; p < N; p++) begin
            d_addr[p] = '0; d_write[p] = 0; d_wdata[p] = '0; d_wstrb[p] = '0; d_valid[p] = 0;
        end
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_nonzero", 64'(rsp_o != '0), 64'd0);
        rst_n = 1;

        // 1: full write then read back
        xfer(0, 1, BASE + 'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("t1_wr_err", 64'(er), 64'd0);
        chk("t1_wr_lat", 64'(lat), 64'd3);
        chk("t1_wr_rdata", 64'(rd), 64'd0);
        xfer(0, 0, BASE + 'h10, '0, '0, rd, er, lat);
        chk("t1_rd_data", 64'(rd), 64'hDEADBEEF);

        // 2: byte strobes
        xfer(0, 1, BASE + 'h20, 32'h11223344, 4'hF, rd, er, lat);
        xfer(0, 1, BASE + 'h20, 32'h000000AA, 4'h1, rd, er, lat);
        xfer(0, 0, BASE + 'h20, '0, '0, rd, er, lat);
        chk("t2_strb1", 64'(rd), 64'h112233AA);
        xfer(0, 1, BASE + 'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        xfer(0, 0, BASE + 'h20, '0, '0, rd, er, lat);
        chk("t2_strb0", 64'(rd), 64'h112233AA);

        // 3: out-of-range on both sides, array untouched
        xfer(1, 0, BASE + NW*4, '0, '0, rd, er, lat);
        chk("t3_hi_err", 64'(er), 64'd1);
        chk("t3_hi_rdata", 64'(rd), 64'd0);
        chk("t3_hi_lat", 64'(lat), 64'd3);
        xfer(1, 1, BASE - 4, 32'h55555555, 4'hF, rd, er, lat);
        chk("t3_lo_err", 64'(er), 64'd1);
        chk("t3_lo_lat", 64'(lat), 64'd3);
        xfer(1, 0, BASE + NW*4 - 4, '0, '0, rd, er, lat);
        chk("t3_last_err", 64'(er), 64'd0);
        chk("t3_last_rdata", 64'(rd), 64'd0);
        xfer(1, 0, BASE + 'h13, '0, '0, rd, er, lat);
        chk("t3_keep_10_unaligned", 64'(rd), 64'hDEADBEEF);
        xfer(1, 0, BASE + 'h20, '0, '0, rd, er, lat);
        chk("t3_keep_20", 64'(rd), 64'h112233AA);

        // 4: simultaneous requests after reset, pointer at 0
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        fork
            xfer(0, 1, BASE, 32'hCAFE0001, 4'hF, rd0, er0, lat0);
            xfer(1, 0, BASE, '0, '0, rd1, er1, lat1);
            xfer(2, 0, BASE + 4, '0, '0, rd2, er2, lat2);
        join
        chk("t4_lat0", 64'(lat0), 64'd3);
        chk("t4_lat1", 64'(lat1), 64'd4);
        chk("t4_lat2", 64'(lat2), 64'd5);
        chk("t4_rd1_sees_write", 64'(rd1), 64'hCAFE0001);
        chk("t4_rd2", 64'(rd2), 64'd0);

        // 5: fairness under continuous re-requests from the other ports
        stop = 0;
        fork
            begin : ham0
                int k;
                k = 0;
                while (!stop) begin
                    xfer(0, 1, BASE + 'h40, 32'hA5000000 + 32'(k), 4'hF, rd0, er0, lat0);
                    k++;
                end
            end
            begin : ham2
                while (!stop) xfer(2, 0, BASE + 'h40, '0, '0, rd2, er2, lat2);
            end
            begin : port1
                for (int i = 0; i < 170; i++) begin
                    xfer(1, i[0], BASE + 'h44, 32'(i), 4'hF, rd1, er1, lat1);
                    chk("t5_p1_lat_bound", 64'(lat1 >= L && lat1 <= L + N - 1), 64'd1);
                end
                stop = 1;
            end
        join

        // 6: reset while a read is in flight
        xfer(0, 1, BASE, 32'h5, 4'hF, rd, er, lat);
        @(negedge clk);
        d_addr[0] = BASE; d_write[0] = 0; d_wstrb[0] = '0; d_valid[0] = 1;
        @(negedge clk);
        rst_n = 0; d_valid[0] = 0;
        @(negedge clk);
        rst_n = 1;
        nready = 0;
        repeat (6) begin
            @(negedge clk);
            for (int p = 0; p < N; p++) if (rsp_o[p*RSPW]) nready++;
        end
        chk("t6_no_late_ready", 64'(nready), 64'd0);
        xfer(1, 0, BASE, '0, '0, rd, er, lat);
        chk("t6_rd_cleared", 64'(rd), 64'd0);
        chk("t6_rd_err", 64'(er), 64'd0);
        xfer(2, 0, BASE + 'h40, '0, '0, rd, er, lat);
        chk("t6_rd40_cleared", 64'(rd), 64'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
